// File: rtl/oppm_tx_arbiter_if.sv
// Bundle of client-side and Encoder-side signals around the OPPM TX arbiter.
//   req / req_data     : packet requests from N_REQ sources
//   grant / done       : one-hot per-source handshake pulses
//   busy / owner       : arbiter status and current/last granted source
//   enc_data/enc_start : packet and start pulse toward the Encoder
//   enc_avail          : Encoder idle indication
// master: the sources plus the Encoder (drive requests and avail).
// slave : the arbiter itself.
interface oppm_tx_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int N_PKT = 16
);
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       req;
    logic [N_REQ*N_PKT-1:0] req_data;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       done;
    logic                   busy;
    logic [OW-1:0]          owner;
    logic [N_PKT-1:0]       enc_data;
    logic                   enc_start;
    logic                   enc_avail;

    modport master (
        output req, req_data, enc_avail,
        input  grant, done, busy, owner, enc_data, enc_start
    );

    modport slave (
        input  req, req_data, enc_avail,
        output grant, done, busy, owner, enc_data, enc_start
    );
endinterface

// File: rtl/oppm_tx_arbiter.sv
// Round-robin arbiter sharing one OPPM Encoder between N_REQ packet sources.
// A winner's packet is latched, the Encoder is started, the arbiter waits for
// the Encoder to report idle again, then holds the line quiet for GAP_CT ticks.
// Ports:
//   clk  : clock
//   rst  : asynchronous reset, active-high
//   bus  : oppm_tx_arbiter_if.slave (req, req_data, enc_avail in;
//          grant, done, busy, owner, enc_data, enc_start out)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a request while the Encoder is available
// S_LAUNCH | one-cycle Encoder start pulse with the latched packet
// S_BUSY   | Encoder transmitting; leaves on the first enc_avail=1
// S_GUARD  | line held idle for GAP_CT cycles, requests ignored
module oppm_tx_arbiter #(
    parameter int N_REQ  = 4,
    parameter int N_PKT  = 16,
    parameter int GAP_CT = 32
) (
    input  logic clk,
    input  logic rst,
    oppm_tx_arbiter_if.slave bus
);
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (GAP_CT > 0) ? $clog2(GAP_CT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_BUSY, S_GUARD} state_t;

    state_t         state_q, state_d;
    logic [OW-1:0]  ptr_q, owner_q;
    logic [OW-1:0]  winner, cand;
    logic           found;
    logic [N_PKT-1:0] pkt_q;
    logic [CW-1:0]  gap_q;
    logic           do_grant, tx_done, gap_end;

    // Scan ptr+1, ptr+2, ... so the last winner ends up with lowest priority.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = OW'((int'(ptr_q) + k) % N_REQ);
            if (!found && bus.req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign do_grant = (state_q == S_IDLE) && bus.enc_avail && found;
    assign tx_done  = (state_q == S_BUSY) && bus.enc_avail;
    assign gap_end  = (state_q == S_GUARD) && (gap_q == CW'(GAP_CT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (do_grant) state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_BUSY;
            S_BUSY:   if (tx_done) state_d = (GAP_CT > 0) ? S_GUARD : S_IDLE;
            S_GUARD:  if (gap_end) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= OW'(N_REQ - 1);
            owner_q <= '0;
            pkt_q   <= '0;
            gap_q   <= '0;
        end else begin
            if (do_grant) begin
                ptr_q   <= winner;
                owner_q <= winner;
                pkt_q   <= bus.req_data[winner*N_PKT +: N_PKT];
            end
            if (tx_done) begin
                gap_q <= '0;
            end else if (state_q == S_GUARD) begin
                gap_q <= gap_q + 1'b1;
            end
        end
    end

    // grant is combinational from req, so it must be masked while rst is high
    // even though the state register already sits in S_IDLE.
    always_comb begin
        bus.grant = '0;
        bus.done  = '0;
        if (do_grant && !rst) bus.grant[winner] = 1'b1;
        if (tx_done) bus.done[owner_q] = 1'b1;
        bus.enc_start = (state_q == S_LAUNCH);
        bus.busy      = (state_q != S_IDLE);
        bus.owner     = owner_q;
        bus.enc_data  = pkt_q;
    end
endmodule
